jtframe_pocket_dwnld: RTL and testbench
=======================================

Name: jtframe_pocket_dwnld

Overview:
Download sequencer between the Pocket APF bridge and the JTFRAME ROM-load (ioctl) interface. It buffers 32-bit bridge writes in a 4-entry FIFO and serialises each word into four byte-wide ioctl writes, paced by a programmable gap and a downstream hold. It owns the `downloading` flag, controlled by a bridge control register. It exposes a readable status word.

Parameters:
DATA_NIB, 4'h1, bridge_addr[31:28] value that selects the data window
CTRL_ADDR, 32'hF800_0000, bridge address of the control/status register
WR_GAP, 4, idle cycles inserted after each ioctl_wr pulse (range 0..15)

Ports:
clk  in  1  system clock; all logic sits in this single domain
rst_n  in  1  reset, asynchronous, active-low
bridge_addr  in  32  bridge address, qualified by bridge_wr/bridge_rd
bridge_wr  in  1  one-cycle bridge write strobe
bridge_wr_data  in  32  bridge write data, big-endian
bridge_rd  in  1  one-cycle bridge read strobe
bridge_rd_data  out  32  registered read data
ioctl_hold  in  1  downstream not ready; stalls byte emission
ioctl_addr  out  25  byte address of the current ioctl write
ioctl_dout  out  8  byte data
ioctl_wr  out  1  one-cycle write pulse
downloading  out  1  a download session is active
fifo_level  out  3  FIFO occupancy, 0..4

Behaviour:
- Reset values: all outputs 0, FIFO empty, serializer IDLE, overflow=0, stop_pend=0.
- Control write (bridge_wr && bridge_addr==CTRL_ADDR):
  - bit0=1 while downloading=0: downloading<=1 on the next edge. While already downloading it has no effect and also clears stop_pend.
  - bit0=0 while downloading=1: stop_pend<=1.
  - bit1=1: clears overflow.
- Data write (bridge_wr && bridge_addr[31:28]==DATA_NIB):
  - Downloading=1 and level<4 before this cycle: push {bridge_addr[24:2], bridge_wr_data}.
  - Downloading=1 and level==4 before this cycle: write dropped, overflow<=1. This holds even if a pop occurs in the same cycle.
  - Downloading=0: write dropped, overflow unchanged.
- Simultaneous push and pop: level is unchanged. FIFO pointers are 2-bit and wrap modulo 4.
- Serializer FSM:
  - IDLE: if FIFO is non-empty, pop the head into the word register, set byte index=0, go to EMIT.
  - EMIT: if ioctl_hold=0, assert ioctl_wr for exactly 1 cycle with ioctl_addr={word_addr,idx[1:0]} and ioctl_dout=word[31-8*idx -: 8]. Byte 0 is data[31:24]. Then go to GAP, or directly to NEXT when WR_GAP==0. If ioctl_hold=1, stay in EMIT with ioctl_wr=0.
  - GAP: count WR_GAP cycles, then go to NEXT.
  - NEXT: if idx==3, go to IDLE; else idx+1 and go to EMIT.
  - ioctl_addr and ioctl_dout hold their last values between pulses.
- Latency: from the push edge, the first ioctl_wr occurs 2 cycles later when the FIFO was empty, the FSM was IDLE and hold=0.
- Word throughput with WR_GAP=G and no hold: 4*(G+2) cycles per word.
- downloading falls one cycle after stop_pend=1, FIFO empty and FSM in IDLE all hold together; stop_pend clears at the same time.
- Hold asserted mid-word: the byte is delayed, never dropped or duplicated.
- Status read (bridge_rd && bridge_addr==CTRL_ADDR): the next cycle bridge_rd_data = {overflow, fifo_level[2:0], 27'd0, downloading}.
- Reads of any other address return 0 the next cycle. bridge_rd_data keeps its value until the next read.
- fifo_level is a combinational view of the registered level.
- Asynchronous reset mid-operation: every state, FIFO entry count and flag returns to reset values immediately. No ioctl_wr is issued after rst_n falls.

Test Plan:
1. Start (CTRL bit0=1), then write addr 0x1000_0010 data 0xA1B2C3D4 with G=4 and hold=0 → ioctl_wr pulses at addr 0x10,0x11,0x12,0x13 with data A1,B2,C3,D4, 6 cycles apart; first pulse 2 cycles after the push.
2. Five back-to-back data writes with hold=1 → fifo_level=4, fifth write dropped, status read returns 0xC000_0001. Write CTRL 0x3 → overflow clears and downloading stays 1.
3. Hold toggled during byte 2 for 7 cycles → exactly 4 pulses in order, byte 2 delayed by 7 cycles, no duplicate.
4. Stop written while 3 words are queued → downloading stays 1 until the 12th pulse completes and the FSM is IDLE, then falls 1 cycle later. Data writes after that point are dropped with no overflow.
5. rst_n pulled low in the middle of EMIT with the FIFO at level 2 → all outputs read 0 at once. After release, no pulses occur without a new start.
6. WR_GAP=0 build, 2 words queued → 8 pulses at 2-cycle spacing, level reaches 0, status read bits[30:28]=0.

Source files
------------

// File: rtl/jtframe_pocket_dwnld_if.sv
// Bridge-side and ioctl-side signals of the Pocket download sequencer.
// The sequencer takes the slave view; whoever drives the bridge takes master.
interface jtframe_pocket_dwnld_if;
  logic [31:0] bridge_addr;
  logic        bridge_wr;
  logic [31:0] bridge_wr_data;
  logic        bridge_rd;
  logic [31:0] bridge_rd_data;
  logic        ioctl_hold;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic        downloading;
  logic [2:0]  fifo_level;

  modport slave (
    input  bridge_addr, bridge_wr, bridge_wr_data, bridge_rd, ioctl_hold,
    output bridge_rd_data, ioctl_addr, ioctl_dout, ioctl_wr, downloading, fifo_level
  );

  modport master (
    output bridge_addr, bridge_wr, bridge_wr_data, bridge_rd, ioctl_hold,
    input  bridge_rd_data, ioctl_addr, ioctl_dout, ioctl_wr, downloading, fifo_level
  );
endinterface

// File: rtl/jtframe_pocket_dwnld.sv
// Pocket APF bridge to JTFRAME ioctl download sequencer: 32-bit bridge words are
// queued in a 4-deep FIFO and replayed as big-endian byte writes with a fixed gap.
module jtframe_pocket_dwnld #(
  parameter logic [3:0]  DATA_NIB  = 4'h1,
  parameter logic [31:0] CTRL_ADDR = 32'hF800_0000,
  parameter int unsigned WR_GAP    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  jtframe_pocket_dwnld_if.slave  bus
);

  localparam int         ENTRY_W  = 55;
  localparam logic [3:0] GAP_LAST = (WR_GAP == 0) ? 4'd0 : 4'(WR_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_GAP,
    S_NEXT
  } state_t;

  // ---------------------------------------------------------------
  // Bridge decode
  // ---------------------------------------------------------------
  logic ctrl_wr;
  logic data_wr;
  logic stat_rd;

  assign ctrl_wr = bus.bridge_wr && (bus.bridge_addr == CTRL_ADDR);
  assign data_wr = bus.bridge_wr && (bus.bridge_addr[31:28] == DATA_NIB);
  assign stat_rd = bus.bridge_addr == CTRL_ADDR;

  // ---------------------------------------------------------------
  // State declarations
  // ---------------------------------------------------------------
  logic               downloading_q;
  logic               stop_pend_q;
  logic               overflow_q;
  logic [31:0]        rd_data_q;

  logic [ENTRY_W-1:0] mem_q [4];
  logic [1:0]         wr_ptr_q;
  logic [1:0]         rd_ptr_q;
  logic [2:0]         level_q;
  logic [2:0]         level_d;

  state_t             state_q;
  logic [31:0]        word_q;
  logic [22:0]        waddr_q;
  logic [1:0]         idx_q;
  logic [3:0]         gap_q;
  logic               ioctl_wr_q;
  logic [24:0]        ioctl_addr_q;
  logic [7:0]         ioctl_dout_q;

  // ---------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               drop_full;
  logic [ENTRY_W-1:0] head;

  assign fifo_full  = (level_q == 3'd4);
  assign fifo_empty = (level_q == 3'd0);
  assign push       = data_wr && downloading_q && !fifo_full;
  // Fullness is judged on the level before this cycle, so a same-cycle pop does not rescue it.
  assign drop_full  = data_wr && downloading_q && fifo_full;
  // The last byte's NEXT state fetches the following word itself to keep the word cadence tight.
  assign pop        = !fifo_empty &&
                      ((state_q == S_IDLE) || ((state_q == S_NEXT) && (idx_q == 2'd3)));
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 3'd1;
      2'b01:   level_d = level_q - 3'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.bridge_addr[24:2], bus.bridge_wr_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      level_q  <= 3'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      level_q <= level_d;
    end
  end

  // ---------------------------------------------------------------
  // Session control, overflow flag and status read
  // ---------------------------------------------------------------
  logic stop_fire;

  // A control write in the same cycle is honoured first; the stop retries next cycle.
  assign stop_fire = stop_pend_q && fifo_empty && (state_q == S_IDLE) && !ctrl_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      downloading_q <= 1'b0;
      stop_pend_q   <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      if (stop_fire) begin
        downloading_q <= 1'b0;
        stop_pend_q   <= 1'b0;
      end
      if (ctrl_wr) begin
        if (bus.bridge_wr_data[0]) begin
          downloading_q <= 1'b1;
          stop_pend_q   <= 1'b0;
        end else if (downloading_q) begin
          stop_pend_q   <= 1'b1;
        end
        if (bus.bridge_wr_data[1]) overflow_q <= 1'b0;
      end
      if (drop_full) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= 32'd0;
    end else if (bus.bridge_rd) begin
      rd_data_q <= stat_rd ? {overflow_q, level_q, 27'd0, downloading_q} : 32'd0;
    end
  end

  // ---------------------------------------------------------------
  // Byte serializer
  // ---------------------------------------------------------------
  logic [7:0] word_bytes [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
    assign word_bytes[gi] = word_q[31-8*gi -: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      word_q       <= 32'd0;
      waddr_q      <= 23'd0;
      idx_q        <= 2'd0;
      gap_q        <= 4'd0;
      ioctl_wr_q   <= 1'b0;
      ioctl_addr_q <= 25'd0;
      ioctl_dout_q <= 8'd0;
    end else begin
      ioctl_wr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            waddr_q <= head[ENTRY_W-1:32];
            word_q  <= head[31:0];
            idx_q   <= 2'd0;
            state_q <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (!bus.ioctl_hold) begin
            ioctl_wr_q   <= 1'b1;
            ioctl_addr_q <= {waddr_q, idx_q};
            ioctl_dout_q <= word_bytes[idx_q];
            gap_q        <= 4'd0;
            state_q      <= (WR_GAP == 0) ? S_NEXT : S_GAP;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= S_NEXT;
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        S_NEXT: begin
          if (idx_q == 2'd3) begin
            if (!fifo_empty) begin
              waddr_q <= head[ENTRY_W-1:32];
              word_q  <= head[31:0];
              idx_q   <= 2'd0;
              state_q <= S_EMIT;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            idx_q   <= idx_q + 2'd1;
            state_q <= S_EMIT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------
  assign bus.bridge_rd_data = rd_data_q;
  assign bus.ioctl_addr     = ioctl_addr_q;
  assign bus.ioctl_dout     = ioctl_dout_q;
  assign bus.ioctl_wr       = ioctl_wr_q;
  assign bus.downloading    = downloading_q;
  assign bus.fifo_level     = level_q;

endmodule

// File: tb/tb_jtframe_pocket_dwnld.sv
// Directed bench for the download sequencer: one DUT with a 4-cycle write gap
// and one built with no gap, each with its own ioctl pulse log.
module tb_jtframe_pocket_dwnld;

  localparam logic [31:0] CTRL = 32'hF800_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtframe_pocket_dwnld_if b0 ();
  jtframe_pocket_dwnld_if b1 ();

  jtframe_pocket_dwnld #(.WR_GAP(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  jtframe_pocket_dwnld #(.WR_GAP(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  typedef struct {
    int          c;
    logic [24:0] a;
    logic [7:0]  d;
  } pulse_t;

  pulse_t q0[$];
  pulse_t q1[$];
  int     cyc   = 0;
  int     n_vec = 0;
  int     n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    pulse_t p;
    if (b0.ioctl_wr === 1'b1) begin
      p.c = cyc; p.a = b0.ioctl_addr; p.d = b0.ioctl_dout;
      q0.push_back(p);
      $display("dut0 pulse cyc=%0d addr=%h data=%h", cyc, b0.ioctl_addr, b0.ioctl_dout);
    end
    if (b1.ioctl_wr === 1'b1) begin
      p.c = cyc; p.a = b1.ioctl_addr; p.d = b1.ioctl_dout;
      q1.push_back(p);
      $display("dut1 pulse cyc=%0d addr=%h data=%h", cyc, b1.ioctl_addr, b1.ioctl_dout);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr0(input logic [31:0] a, input logic [31:0] d);
    b0.bridge_addr    = a;
    b0.bridge_wr_data = d;
    b0.bridge_wr      = 1'b1;
    @(posedge clk);
    #1;
    b0.bridge_wr = 1'b0;
  endtask

  task automatic rd0(input logic [31:0] a);
    b0.bridge_addr = a;
    b0.bridge_rd   = 1'b1;
    @(posedge clk);
    #1;
    b0.bridge_rd = 1'b0;
  endtask

  task automatic test_reset();
    idle(2);
    n_vec++;
    if ({b0.bridge_rd_data, b0.ioctl_addr, b0.ioctl_dout, b0.ioctl_wr, b0.downloading, b0.fifo_level} !== 71'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rd=%h addr=%h dout=%h wr=%b dl=%b lvl=%0d want all 0",
               b0.bridge_rd_data, b0.ioctl_addr, b0.ioctl_dout, b0.ioctl_wr, b0.downloading, b0.fifo_level);
    end
    rst_n = 1'b1;
    idle(2);
    n_vec++;
    if (b0.downloading !== 1'b0 || b0.fifo_level !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_release: got dl=%b lvl=%0d want 0 0", b0.downloading, b0.fifo_level);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] ed [4];
    int t0;
    ed = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    wr0(CTRL, 32'h1);
    n_vec++;
    if (b0.downloading !== 1'b1) begin
      n_bad++; $display("FAIL start: got dl=%b want 1", b0.downloading);
    end
    q0.delete();
    wr0(32'h1000_0010, 32'hA1B2_C3D4);
    t0 = cyc;
    for (int i = 0; i < 60 && q0.size() < 4; i++) idle(1);
    n_vec++;
    if (q0.size() != 4) begin
      n_bad++; $display("FAIL single_count: got %0d want 4", q0.size());
    end
    for (int i = 0; i < 4 && i < q0.size(); i++) begin
      n_vec++;
      if (q0[i].a !== 25'(32'h10 + i) || q0[i].d !== ed[i] || q0[i].c - t0 != 2 + 6 * i) begin
        n_bad++;
        $display("FAIL single_byte%0d: got addr=%h data=%h dt=%0d want addr=%h data=%h dt=%0d",
                 i, q0[i].a, q0[i].d, q0[i].c - t0, 32'h10 + i, ed[i], 2 + 6 * i);
      end
    end
    idle(10);
    n_vec++;
    if (q0.size() != 4) begin
      n_bad++; $display("FAIL single_extra: got %0d pulses want 4", q0.size());
    end
  endtask

  task automatic test_overflow();
    int w;
    b0.ioctl_hold = 1'b1;
    q0.delete();
    wr0(32'h1000_0100, 32'h0001_0203);
    idle(3);
    for (int i = 0; i < 5; i++) begin
      w = i + 1;
      wr0(32'h1000_0100 + 32'(4 * w), {8'(4 * w), 8'(4 * w + 1), 8'(4 * w + 2), 8'(4 * w + 3)});
    end
    n_vec++;
    if (b0.fifo_level !== 3'd4) begin
      n_bad++; $display("FAIL ovf_level: got %0d want 4", b0.fifo_level);
    end
    rd0(CTRL);
    n_vec++;
    if (b0.bridge_rd_data !== 32'hC000_0001) begin
      n_bad++; $display("FAIL ovf_status: got %h want c0000001", b0.bridge_rd_data);
    end
    wr0(CTRL, 32'h3);
    rd0(CTRL);
    n_vec++;
    if (b0.bridge_rd_data !== 32'h4000_0001) begin
      n_bad++; $display("FAIL ovf_clear: got %h want 40000001", b0.bridge_rd_data);
    end
    rd0(32'h1234_5678);
    n_vec++;
    if (b0.bridge_rd_data !== 32'h0) begin
      n_bad++; $display("FAIL other_read: got %h want 0", b0.bridge_rd_data);
    end
    b0.ioctl_hold = 1'b0;
    for (int i = 0; i < 400 && q0.size() < 20; i++) idle(1);
    idle(20);
    n_vec++;
    if (q0.size() != 20) begin
      n_bad++; $display("FAIL ovf_count: got %0d pulses want 20", q0.size());
    end
    for (int i = 0; i < 20 && i < q0.size(); i++) begin
      n_vec++;
      if (q0[i].a !== 25'(32'h100 + i) || q0[i].d !== 8'(i)) begin
        n_bad++;
        $display("FAIL ovf_byte%0d: got addr=%h data=%h want addr=%h data=%h",
                 i, q0[i].a, q0[i].d, 32'h100 + i, 8'(i));
      end
    end
  endtask

  task automatic test_hold_mid_word();
    logic [7:0] ed [4];
    int         ec [4];
    int t0;
    ed = '{8'h11, 8'h22, 8'h33, 8'h44};
    ec = '{2, 8, 21, 27};
    q0.delete();
    wr0(32'h1000_0020, 32'h1122_3344);
    t0 = cyc;
    idle(13);
    b0.ioctl_hold = 1'b1;
    idle(7);
    b0.ioctl_hold = 1'b0;
    for (int i = 0; i < 60 && q0.size() < 4; i++) idle(1);
    idle(10);
    n_vec++;
    if (q0.size() != 4) begin
      n_bad++; $display("FAIL hold_count: got %0d want 4", q0.size());
    end
    for (int i = 0; i < 4 && i < q0.size(); i++) begin
      n_vec++;
      if (q0[i].a !== 25'(32'h20 + i) || q0[i].d !== ed[i] || q0[i].c - t0 != ec[i]) begin
        n_bad++;
        $display("FAIL hold_byte%0d: got addr=%h data=%h dt=%0d want addr=%h data=%h dt=%0d",
                 i, q0[i].a, q0[i].d, q0[i].c - t0, 32'h20 + i, ed[i], ec[i]);
      end
    end
  endtask

  task automatic test_stop();
    int fall = -1;
    b0.ioctl_hold = 1'b1;
    q0.delete();
    for (int i = 0; i < 3; i++) wr0(32'h1000_0200 + 32'(4 * i), 32'hC0C1_C2C3 + 32'h1010_1010 * 32'(i));
    wr0(CTRL, 32'h0);
    idle(5);
    n_vec++;
    if (b0.downloading !== 1'b1 || b0.fifo_level !== 3'd2) begin
      n_bad++; $display("FAIL stop_pending: got dl=%b lvl=%0d want 1 2", b0.downloading, b0.fifo_level);
    end
    b0.ioctl_hold = 1'b0;
    for (int i = 0; i < 300; i++) begin
      idle(1);
      if (b0.downloading === 1'b0) begin
        fall = cyc;
        break;
      end
    end
    n_vec++;
    if (q0.size() != 12) begin
      n_bad++; $display("FAIL stop_count: got %0d pulses want 12", q0.size());
    end
    if (q0.size() >= 12) begin
      n_vec++;
      if (fall - q0[11].c != 6 || q0[11].d !== 8'hE3 || q0[11].a !== 25'h20B) begin
        n_bad++;
        $display("FAIL stop_fall: got dt=%0d last=%h@%h want dt=6 last=e3@20b", fall - q0[11].c, q0[11].d, q0[11].a);
      end
    end
    wr0(32'h1000_0300, 32'hDEAD_0000);
    idle(8);
    n_vec++;
    if (b0.fifo_level !== 3'd0 || q0.size() != 12) begin
      n_bad++; $display("FAIL stop_drop: got lvl=%0d pulses=%0d want 0 12", b0.fifo_level, q0.size());
    end
    rd0(CTRL);
    n_vec++;
    if (b0.bridge_rd_data !== 32'h0) begin
      n_bad++; $display("FAIL stop_status: got %h want 0", b0.bridge_rd_data);
    end
  endtask

  task automatic test_reset_mid();
    wr0(CTRL, 32'h1);
    b0.ioctl_hold = 1'b1;
    for (int i = 0; i < 3; i++) wr0(32'h1000_0500 + 32'(4 * i), 32'h5555_0000 + 32'(i));
    idle(2);
    rd0(CTRL);
    n_vec++;
    if (b0.bridge_rd_data !== 32'h2000_0001) begin
      n_bad++; $display("FAIL rstmid_pre: got %h want 20000001", b0.bridge_rd_data);
    end
    q0.delete();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({b0.bridge_rd_data, b0.ioctl_addr, b0.ioctl_dout, b0.ioctl_wr, b0.downloading, b0.fifo_level} !== 71'd0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got rd=%h addr=%h dout=%h wr=%b dl=%b lvl=%0d want all 0",
               b0.bridge_rd_data, b0.ioctl_addr, b0.ioctl_dout, b0.ioctl_wr, b0.downloading, b0.fifo_level);
    end
    idle(2);
    rst_n = 1'b1;
    b0.ioctl_hold = 1'b0;
    wr0(32'h1000_0600, 32'h0BAD_F00D);
    idle(30);
    n_vec++;
    if (q0.size() != 0 || b0.fifo_level !== 3'd0 || b0.downloading !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_after: got pulses=%0d lvl=%0d dl=%b want 0 0 0", q0.size(), b0.fifo_level, b0.downloading);
    end
  endtask

  task automatic test_nogap();
    logic [7:0] ed [8];
    int t0;
    ed = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    q1.delete();
    b1.bridge_addr = CTRL; b1.bridge_wr_data = 32'h1; b1.bridge_wr = 1'b1;
    idle(1);
    b1.bridge_addr = 32'h1000_0040; b1.bridge_wr_data = 32'hDEAD_BEEF;
    idle(1);
    t0 = cyc;
    b1.bridge_addr = 32'h1000_0044; b1.bridge_wr_data = 32'h0123_4567;
    idle(1);
    b1.bridge_wr = 1'b0;
    for (int i = 0; i < 60 && q1.size() < 8; i++) idle(1);
    idle(5);
    n_vec++;
    if (q1.size() != 8) begin
      n_bad++; $display("FAIL nogap_count: got %0d want 8", q1.size());
    end
    for (int i = 0; i < 8 && i < q1.size(); i++) begin
      n_vec++;
      if (q1[i].a !== 25'(32'h40 + i) || q1[i].d !== ed[i] || q1[i].c - t0 != 2 + 2 * i) begin
        n_bad++;
        $display("FAIL nogap_byte%0d: got addr=%h data=%h dt=%0d want addr=%h data=%h dt=%0d",
                 i, q1[i].a, q1[i].d, q1[i].c - t0, 32'h40 + i, ed[i], 2 + 2 * i);
      end
    end
    b1.bridge_addr = CTRL; b1.bridge_rd = 1'b1;
    idle(1);
    b1.bridge_rd = 1'b0;
    n_vec++;
    if (b1.bridge_rd_data !== 32'h0000_0001 || b1.fifo_level !== 3'd0) begin
      n_bad++; $display("FAIL nogap_status: got %h lvl=%0d want 00000001 0", b1.bridge_rd_data, b1.fifo_level);
    end
  endtask

  initial begin
    b0.bridge_addr = '0; b0.bridge_wr = 1'b0; b0.bridge_wr_data = '0; b0.bridge_rd = 1'b0; b0.ioctl_hold = 1'b0;
    b1.bridge_addr = '0; b1.bridge_wr = 1'b0; b1.bridge_wr_data = '0; b1.bridge_rd = 1'b0; b1.ioctl_hold = 1'b0;
    test_reset();
    test_single_word();
    test_overflow();
    test_hold_mid_word();
    test_stop();
    test_reset_mid();
    test_nogap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
